// File: rtl/tod_pkg.sv
// Shared BCD types, constants and helpers for the time-of-day clock.
package tod_pkg;

    typedef logic [7:0] bcd8_t;

    localparam bcd8_t HOUR_RESET   = 8'h12;
    localparam bcd8_t HOUR_MIN     = 8'h01;
    localparam bcd8_t HOUR_PM_EDGE = 8'h11;
    localparam bcd8_t BCD_59       = 8'h59;
    localparam bcd8_t BCD_ZERO     = 8'h00;

    // One BCD step: low digit 9 rolls to 0 and carries into the high digit.
    function automatic bcd8_t bcd_inc(input bcd8_t v);
        bcd8_t r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // True when both nibbles are decimal digits.
    function automatic logic bcd_digits_ok(input bcd8_t v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD modulo-60 counter used for both seconds and minutes.
module bcd_mod60_counter
    import tod_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_i,
    input  logic  load_i,
    input  bcd8_t load_val_i,
    output bcd8_t value_o,
    output logic  carry_c_o
);

    bcd8_t value_q;
    bcd8_t value_d;

    // Next value: a load wins over counting; 59 wraps to 00.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (en_i) begin
            value_d = (value_q == BCD_59) ? BCD_ZERO : bcd_inc(value_q);
        end
    end

    // Carry fires in the same cycle the counter wraps 59 -> 00.
    assign carry_c_o = en_i && !load_i && (value_q == BCD_59);

    // Value register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/time_of_day_clock.sv
// 12-hour BCD time-of-day clock driven by a 1 Hz strobe from a clk prescaler.
// Optional feature macro: TOD_TIME_SET_EN adds the set_* ports and time-load logic.
module time_of_day_clock
    import tod_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
`ifdef TOD_TIME_SET_EN
    input  logic       set_valid,
    input  logic [7:0] set_hours,
    input  logic [7:0] set_minutes,
    input  logic       set_pm,
    output logic       set_err,
`endif
    output logic [7:0] hours,
    output logic [7:0] minutes,
    output logic [7:0] seconds,
    output logic       pm,
    output logic       hour_tick
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    bcd8_t              hours_q;
    bcd8_t              hours_d;
    logic               pm_q;
    logic               pm_d;
    logic               hour_tick_q;
    logic               hour_tick_d;

    logic  strobe_c;
    logic  load_c;
    bcd8_t load_hours_c;
    bcd8_t load_minutes_c;
    logic  load_pm_c;
    logic  sec_carry_c;
    logic  min_carry_c;
    bcd8_t sec_value;
    bcd8_t min_value;

    assign strobe_c = (presc_q == PRESC_MAX);

`ifdef TOD_TIME_SET_EN
    logic req_ok_c;
    logic set_err_q;
    logic set_err_d;

    // A request is legal only with decimal digits, hours 01..12 and minutes 00..59.
    assign req_ok_c = bcd_digits_ok(set_hours) && bcd_digits_ok(set_minutes)
                   && (set_hours != BCD_ZERO) && (set_hours <= HOUR_RESET)
                   && (set_minutes <= BCD_59);

    assign load_c         = set_valid && req_ok_c;
    assign set_err_d      = set_valid && !req_ok_c;
    assign load_hours_c   = set_hours;
    assign load_minutes_c = set_minutes;
    assign load_pm_c      = set_pm;

    // Reject pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_err_q <= 1'b0;
        end else begin
            set_err_q <= set_err_d;
        end
    end

    assign set_err = set_err_q;
`else
    assign load_c         = 1'b0;
    assign load_hours_c   = HOUR_RESET;
    assign load_minutes_c = BCD_ZERO;
    assign load_pm_c      = 1'b0;
`endif

    // Prescaler restarts on its own wrap and on an accepted load.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if (load_c || strobe_c) begin
            presc_d = '0;
        end
    end

    // Seconds: a load clears them and swallows a coincident strobe.
    bcd_mod60_counter u_seconds (
        .clk        (clk),
        .rst        (rst),
        .en_i       (strobe_c && !load_c),
        .load_i     (load_c),
        .load_val_i (BCD_ZERO),
        .value_o    (sec_value),
        .carry_c_o  (sec_carry_c)
    );

    // Minutes advance on the seconds wrap.
    bcd_mod60_counter u_minutes (
        .clk        (clk),
        .rst        (rst),
        .en_i       (sec_carry_c),
        .load_i     (load_c),
        .load_val_i (load_minutes_c),
        .value_o    (min_value),
        .carry_c_o  (min_carry_c)
    );

    // Hours in 12-hour form: 11 -> 12 flips AM/PM, 12 -> 01 keeps it.
    always_comb begin
        hours_d     = hours_q;
        pm_d        = pm_q;
        hour_tick_d = 1'b0;
        if (load_c) begin
            hours_d = load_hours_c;
            pm_d    = load_pm_c;
        end else if (min_carry_c) begin
            hour_tick_d = 1'b1;
            if (hours_q == HOUR_RESET) begin
                hours_d = HOUR_MIN;
            end else begin
                hours_d = bcd_inc(hours_q);
                if (hours_q == HOUR_PM_EDGE) begin
                    pm_d = ~pm_q;
                end
            end
        end
    end

    // State registers; reset overrides loads and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            hours_q     <= HOUR_RESET;
            pm_q        <= 1'b0;
            hour_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hours_q     <= hours_d;
            pm_q        <= pm_d;
            hour_tick_q <= hour_tick_d;
        end
    end

    assign hours     = hours_q;
    assign minutes   = min_value;
    assign seconds   = sec_value;
    assign pm        = pm_q;
    assign hour_tick = hour_tick_q;

endmodule

// File: tb/tb_time_of_day_clock.sv
// Scoreboard bench for time_of_day_clock; reference model keeps time as seconds-of-day.
module tb_time_of_day_clock;

    localparam int unsigned TPS = 4;
`ifdef TOD_TIME_SET_EN
    localparam bit SET_EN = 1'b1;
`else
    localparam bit SET_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       pm;
    logic       hour_tick;
`ifdef TOD_TIME_SET_EN
    logic       set_valid   = 1'b0;
    logic [7:0] set_hours   = 8'h12;
    logic [7:0] set_minutes = 8'h00;
    logic       set_pm      = 1'b0;
    logic       set_err;
`endif

    always #5 clk = ~clk;

    time_of_day_clock #(.TICKS_PER_SEC(TPS)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TOD_TIME_SET_EN
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .set_pm      (set_pm),
        .set_err     (set_err),
`endif
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .pm          (pm),
        .hour_tick   (hour_tick)
    );

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       pm;
        logic       tick;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   ticks_seen = 0;
    int   errs_seen  = 0;

    // Reference state: seconds since 12:00:00 AM and prescaler phase.
    int sod   = 0;
    int presc = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return (32'(v[7:4]) * 10) + 32'(v[3:0]);
    endfunction

    function automatic bit req_legal(input logic [7:0] sh, input logic [7:0] sm);
        int hh;
        int mm;
        if (sh[7:4] > 4'd9 || sh[3:0] > 4'd9 || sm[7:4] > 4'd9 || sm[3:0] > 4'd9) return 1'b0;
        hh = from_bcd(sh);
        mm = from_bcd(sm);
        return (hh >= 1) && (hh <= 12) && (mm <= 59);
    endfunction

    function automatic exp_t model_view(input logic tick, input logic err);
        exp_t e;
        int   h24;
        h24    = sod / 3600;
        e.h    = to_bcd((h24 % 12 == 0) ? 12 : h24 % 12);
        e.m    = to_bcd((sod / 60) % 60);
        e.s    = to_bcd(sod % 60);
        e.pm   = (h24 >= 12);
        e.tick = tick;
        e.err  = err;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and push the expected post-edge outputs.
    task automatic step(input logic r, input logic sv, input logic [7:0] sh,
                        input logic [7:0] sm, input logic sp);
        logic tick;
        logic err;
        int   old_h;
        int   hh;
        @(negedge clk);
        rst = r;
`ifdef TOD_TIME_SET_EN
        set_valid   = sv;
        set_hours   = sh;
        set_minutes = sm;
        set_pm      = sp;
`endif
        tick = 1'b0;
        err  = 1'b0;
        if (r) begin
            sod   = 0;
            presc = 0;
        end else if (SET_EN && sv && req_legal(sh, sm)) begin
            hh    = from_bcd(sh);
            sod   = (((hh % 12) + (sp ? 12 : 0)) * 3600) + (from_bcd(sm) * 60);
            presc = 0;
        end else begin
            err = SET_EN && sv;
            if (presc == int'(TPS) - 1) begin
                presc = 0;
                old_h = sod / 3600;
                sod   = (sod + 1) % 86400;
                tick  = ((sod / 3600) != old_h);
            end else begin
                presc++;
            end
        end
        exp_q.push_back(model_view(tick, err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    // Wait until the last pushed expectation has been compared.
    task automatic settle();
        @(posedge clk);
        #3;
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        logic act_err;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
`ifdef TOD_TIME_SET_EN
                act_err = set_err;
`else
                act_err = 1'b0;
`endif
                if (hour_tick === 1'b1) ticks_seen++;
                if (act_err === 1'b1) errs_seen++;
                checks++;
                if (hours !== e.h || minutes !== e.m || seconds !== e.s || pm !== e.pm
                    || hour_tick !== e.tick || act_err !== e.err) begin
                    fails++;
                    $display("FAIL scoreboard @%0t: got %h:%h:%h pm=%b tick=%b err=%b expected %h:%h:%h pm=%b tick=%b err=%b",
                             $time, hours, minutes, seconds, pm, hour_tick, act_err,
                             e.h, e.m, e.s, e.pm, e.tick, e.err);
                end
            end
        end
    end

    initial begin
        int guard;
        logic       sv;
        logic [7:0] sh;
        logic [7:0] sm;

        // Reset state.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        settle();
        chk("reset_hours", 32'(hours), 32'h12);
        chk("reset_minutes", 32'(minutes), 32'h00);
        chk("reset_pm", 32'(pm), 32'h0);

        // Three seconds from reset.
        ticks_seen = 0;
        idle(3 * TPS);
        settle();
        chk("run3_seconds", 32'(seconds), 32'h03);
        chk("run3_hours", 32'(hours), 32'h12);
        chk("run3_pm", 32'(pm), 32'h0);
        chk("run3_no_tick", 32'(ticks_seen), 32'd0);

`ifdef TOD_TIME_SET_EN
        // 11:59 AM rolls to 12:00 PM.
        step(1'b0, 1'b1, 8'h11, 8'h59, 1'b0);
        ticks_seen = 0;
        idle(60 * TPS);
        settle();
        chk("noon_hours", 32'(hours), 32'h12);
        chk("noon_minutes", 32'(minutes), 32'h00);
        chk("noon_seconds", 32'(seconds), 32'h00);
        chk("noon_pm", 32'(pm), 32'h1);
        chk("noon_ticks", 32'(ticks_seen), 32'd1);

        // 12:59 PM rolls to 01:00 PM.
        step(1'b0, 1'b1, 8'h12, 8'h59, 1'b1);
        ticks_seen = 0;
        idle(60 * TPS);
        settle();
        chk("one_hours", 32'(hours), 32'h01);
        chk("one_pm", 32'(pm), 32'h1);
        chk("one_ticks", 32'(ticks_seen), 32'd1);

        // 09:59 AM carries into 10.
        step(1'b0, 1'b1, 8'h09, 8'h59, 1'b0);
        idle(60 * TPS);
        settle();
        chk("ten_hours", 32'(hours), 32'h10);
        chk("ten_minutes", 32'(minutes), 32'h00);

        // Rejected requests, issued away from a strobe edge.
        errs_seen = 0;
        guard = 0;
        while (presc == int'(TPS) - 1 && guard < 10) begin idle(1); guard++; end
        step(1'b0, 1'b1, 8'h13, 8'h30, 1'b0);
        idle(2);
        settle();
        chk("err_hours13", 32'(errs_seen), 32'd1);
        chk("err_keep_hours", 32'(hours), 32'h10);
        guard = 0;
        while (presc == int'(TPS) - 1 && guard < 10) begin idle(1); guard++; end
        step(1'b0, 1'b1, 8'h05, 8'h5A, 1'b0);
        idle(2);
        settle();
        chk("err_min5A", 32'(errs_seen), 32'd2);
        chk("err_keep_minutes", 32'(minutes), 32'h00);

        // Set coinciding with a strobe, then reset at 11:59:59 PM on the strobe cycle.
        guard = 0;
        while (presc != int'(TPS) - 1 && guard < 10) begin idle(1); guard++; end
        chk("align_strobe_timeout", 32'(guard < 10), 32'd1);
        ticks_seen = 0;
        step(1'b0, 1'b1, 8'h11, 8'h59, 1'b1);
        settle();
        chk("set_on_strobe_seconds", 32'(seconds), 32'h00);
        guard = 0;
        while (!((sod % 60) == 59 && presc == int'(TPS) - 1) && guard < 1000) begin
            idle(1);
            guard++;
        end
        chk("align_2359_timeout", 32'(guard < 1000), 32'd1);
        settle();
        chk("pre_reset_seconds", 32'(seconds), 32'h59);
        chk("pre_reset_pm", 32'(pm), 32'h1);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        settle();
        chk("rst_roll_hours", 32'(hours), 32'h12);
        chk("rst_roll_seconds", 32'(seconds), 32'h00);
        chk("rst_roll_pm", 32'(pm), 32'h0);
        chk("rst_roll_tick", 32'(hour_tick), 32'h0);
        chk("no_tick_on_set", 32'(ticks_seen), 32'd0);
`endif

        // Randomized traffic: occasional resets and (when present) set requests.
        for (int i = 0; i < 3000; i++) begin
            sv = 1'b0;
            sh = 8'h00;
            sm = 8'h00;
            if (SET_EN && $urandom_range(0, 39) == 0) begin
                sv = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    sh = to_bcd(int'($urandom_range(1, 12)));
                    sm = to_bcd(int'($urandom_range(56, 59)));
                end else begin
                    sh = 8'($urandom_range(0, 255));
                    sm = 8'($urandom_range(0, 255));
                end
                if (!req_legal(sh, sm) && presc == int'(TPS) - 1) sv = 1'b0;
            end
            step(1'b0 || ($urandom_range(0, 599) == 0), sv, sh, sm, 1'($urandom_range(0, 1)));
        end

        // Two full hours of counting from reset.
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        ticks_seen = 0;
        idle(2 * 3600 * TPS);
        settle();
        chk("two_hours_hours", 32'(hours), 32'h02);
        chk("two_hours_minutes", 32'(minutes), 32'h00);
        chk("two_hours_pm", 32'(pm), 32'h0);
        chk("two_hours_ticks", 32'(ticks_seen), 32'd2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/time_of_day_clock.md
TIME_OF_DAY_CLOCK -- requirements
Module: time_of_day_clock

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, clk cycles per second; legal range 2 and above.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port set_valid  input  1  time-load request (TIME_SET_EN only).
REQ-005 SHALL have port set_hours  input  8  BCD hours, 8'h01..8'h12 (TIME_SET_EN only).
REQ-006 SHALL have port set_minutes  input  8  BCD minutes, 8'h00..8'h59 (TIME_SET_EN only).
REQ-007 SHALL have port set_pm  input  1  PM flag for the loaded time (TIME_SET_EN only).
REQ-008 SHALL have port set_err  output  1  one-cycle pulse when a set request is rejected (TIME_SET_EN only).
REQ-009 SHALL have port hours  output  8  BCD hours, 12-hour format, 8'h01..8'h12.
REQ-010 SHALL have port minutes  output  8  BCD minutes, 8'h00..8'h59.
REQ-011 SHALL have port seconds  output  8  BCD seconds, 8'h00..8'h59.
REQ-012 SHALL have port pm  output  1  1 = PM, 0 = AM.
REQ-013 SHALL have port hour_tick  output  1  one-cycle pulse in the cycle hours changes by counting.

Function
REQ-014 SHALL keep a prescaler counting 0..TICKS_PER_SEC-1; the wrap of the prescaler is the second strobe.
REQ-015 SHALL advance seconds by one BCD step on each second strobe; all outputs are registered.
REQ-016 SHALL wrap seconds 8'h59 -> 8'h00 and increment minutes in that same cycle.
REQ-017 SHALL wrap minutes 8'h59 -> 8'h00 and increment hours in that same cycle.
REQ-018 SHALL increment the low BCD digit 9 -> 0 with a carry into the high digit; the hours step is 8'h09 -> 8'h10.
REQ-019 SHALL step hours 8'h11 -> 8'h12 and toggle pm in that same cycle.
REQ-020 SHALL step hours 8'h12 -> 8'h01 with pm unchanged.
REQ-021 SHALL assert hour_tick for exactly the one cycle in which hours is updated by counting; a set SHALL NOT assert it.
REQ-022 SHALL never present a non-BCD or out-of-range value on hours, minutes or seconds.

Reset
REQ-023 SHALL, when rst is high at a clock edge, set hours=8'h12, minutes=8'h00, seconds=8'h00, pm=0, hour_tick=0, set_err=0 and prescaler=0.
REQ-024 SHALL give rst priority over set_valid and over the second strobe, including in the cycle a rollover would occur.

Configuration
REQ-025 SHALL, with macro TOD_TIME_SET_EN defined, include the set ports and the load logic.
REQ-026 SHALL, on a set_valid cycle, check the request; a valid request loads the set values, clears seconds and the prescaler, and takes effect on the next edge.
REQ-027 SHALL reject a request with non-BCD digits, hours of 0 or above 12, or minutes above 59: set_err pulses for one cycle and the time is unchanged.
REQ-028 SHALL, when set_valid coincides with a second strobe, apply the set and discard the strobe, with no hour_tick.
REQ-029 SHALL, without TOD_TIME_SET_EN, have no set ports; the time starts from the reset value only.

Structure
REQ-030 SHALL place in shared package tod_pkg: the BCD constants HOUR_RESET (8'h12), HOUR_MIN (8'h01), BCD_59 (8'h59), and typedef bcd8_t.
REQ-031 SHALL use sub-module bcd_mod60_counter (enable in, BCD value out, carry out) for both seconds and minutes; the hours logic stays in the top module.

Verification
REQ-032 SHALL cover reset then 3*TICKS_PER_SEC cycles with TICKS_PER_SEC=4 -> 12:00:03 AM, no hour_tick.
REQ-033 SHALL cover set 11:59 AM then 60 seconds -> 12:00:00 PM, pm=1, one hour_tick pulse.
REQ-034 SHALL cover set 12:59 PM then 60 seconds -> 01:00:00 PM, pm stays 1.
REQ-035 SHALL cover set 09:59 AM then 60 seconds -> hours=8'h10 (BCD carry), minutes=8'h00.
REQ-036 SHALL cover set_hours=8'h13, then set_minutes=8'h5A -> set_err pulses once each time, time unchanged.
REQ-037 SHALL cover rst asserted at 11:59:59 PM in the second-strobe cycle -> 12:00:00 AM, pm=0, hour_tick=0.
